sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO with a valid/ready interface on both sides. It buffers DATA_WIDTH-bit words up to DEPTH entries, and DEPTH need not be a power of two. It adds features the dual-clock pointer FIFO lacks:
- optional fall-through mode
- synchronous flush
- exact fill level
- programmable almost-full and almost-empty flags

It is used as the same-domain buffer in front of or behind CDC crossings and in peripheral data paths.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 39 +++
 rtl/sync_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO.
// Width derivation and configuration sanity checks.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  function automatic bit cfg_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (depth >= 1) && (af >= 1) && (af <= depth)
        && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer with synchronous clear.
// Wraps explicitly so non-power-of-two depths work.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock valid/ready FIFO with optional fall-through,
// flush, exact level and almost-full/almost-empty flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int FALL_THROUGH = 0,
  parameter int AF_THRESH    = DEPTH - 1,
  parameter int AE_THRESH    = 1,
  parameter int CNT_WIDTH    = cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  output logic [DATA_WIDTH-1:0] dst_data_o,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [CNT_WIDTH-1:0]  level_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam bit FT = (FALL_THROUGH != 0);

  if (!cfg_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_cfg_err
    $error("sync_fifo_ctrl: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  logic empty, full;
  logic push, pop, bypass;
  logic wr_en, rd_inc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_WIDTH'(DEPTH));

  assign src_ready_o = !full;
  assign dst_valid_o = !empty
                    || (FT && src_valid_i && !flush_i);
  assign dst_data_o  = (FT && empty) ? src_data_i
                                     : mem_q[rd_ptr];

  assign push   = src_valid_i && src_ready_o;
  assign pop    = dst_valid_o && dst_ready_i;
  assign bypass = FT && empty && push && pop;

  assign wr_en  = push && !bypass && !flush_i;
  assign rd_inc = pop && !empty && !flush_i;

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (wr_en),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .inc_i   (rd_inc),
    .ptr_o   (rd_ptr)
  );

  // Storage is never reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_en) begin
      mem_q[wr_ptr] <= src_data_i;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign level_o        = count_q;
  assign almost_full_o  = (count_q >= CNT_WIDTH'(AF_THRESH));
  assign almost_empty_o = (count_q <= CNT_WIDTH'(AE_THRESH));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench: two DEPTH=5 FIFOs (registered and
// fall-through) share stimulus, each with its own model.
module tb_sync_fifo_ctrl;

  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int MS = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] src_d = '0;
  logic       src_v = 1'b0;
  logic       dst_r = 1'b0;

  logic [7:0] dd [2];
  logic       dv [2];
  logic       sr [2];
  logic [2:0] lv [2];
  logic       af [2];
  logic       ae [2];

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [2][MS];
  int hd [2];
  int tl [2];
  int e_lvl [2];
  bit e_rdy [2];
  bit e_val [2];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH   (8),
    .DEPTH        (D),
    .FALL_THROUGH (0),
    .AF_THRESH    (AF),
    .AE_THRESH    (AE)
  ) u_reg (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .src_data_i     (src_d),
    .src_valid_i    (src_v),
    .src_ready_o    (sr[0]),
    .dst_data_o     (dd[0]),
    .dst_valid_o    (dv[0]),
    .dst_ready_i    (dst_r),
    .level_o        (lv[0]),
    .almost_full_o  (af[0]),
    .almost_empty_o (ae[0])
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH   (8),
    .DEPTH        (D),
    .FALL_THROUGH (1),
    .AF_THRESH    (AF),
    .AE_THRESH    (AE)
  ) u_ft (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .src_data_i     (src_d),
    .src_valid_i    (src_v),
    .src_ready_o    (sr[1]),
    .dst_data_o     (dd[1]),
    .dst_valid_o    (dv[1]),
    .dst_ready_i    (dst_r),
    .level_o        (lv[1]),
    .almost_full_o  (af[1]),
    .almost_empty_o (ae[1])
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: an unbounded FIFO of accepted words.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_lvl[i] = tl[i] - hd[i];
      e_rdy[i] = (e_lvl[i] != D);
      e_val[i] = (e_lvl[i] != 0)
              || (i == 1 && src_v && !flush);
      if (rst_n && !flush && src_v && e_rdy[i]) begin
        mem[i][tl[i]] = src_d;
        tl[i]++;
      end
    end
  end

  // Monitor: compare outputs, pop scoreboard on handshake.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        chk($sformatf("d%0d_level", i), int'(lv[i]), e_lvl[i]);
        chk($sformatf("d%0d_ready", i), int'(sr[i]),
            int'(e_rdy[i]));
        chk($sformatf("d%0d_valid", i), int'(dv[i]),
            int'(e_val[i]));
        chk($sformatf("d%0d_afull", i), int'(af[i]),
            int'(e_lvl[i] >= AF));
        chk($sformatf("d%0d_aempty", i), int'(ae[i]),
            int'(e_lvl[i] <= AE));
        chk($sformatf("d%0d_le_depth", i),
            int'(lv[i] <= 3'(D)), 1);
        assert (lv[i] <= 3'(D));
        if (dv[i] && dst_r) begin
          if (hd[i] < tl[i]) begin
            chk($sformatf("d%0d_data", i), int'(dd[i]),
                int'(mem[i][hd[i]]));
            hd[i]++;
          end else begin
            chk($sformatf("d%0d_pop_empty", i), 1, 0);
          end
        end
      end
      if (!rst_n || flush) hd[i] = tl[i];
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d,
                     input bit r, input bit f, input bit rn);
    @(posedge clk);
    #1;
    src_v = v;
    src_d = d;
    dst_r = r;
    flush = f;
    rst_n = rn;
  endtask

  initial begin
    hd[0] = 0; hd[1] = 0;
    tl[0] = 0; tl[1] = 0;
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    for (int k = 1; k <= 5; k++) cyc(1, 8'(k * 8'h11), 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'hEE, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(0, 8'h00, 1, 0, 1);
    cyc(1, 8'h20, 0, 0, 1);
    cyc(1, 8'h21, 0, 0, 1);
    for (int k = 2; k < 13; k++) cyc(1, 8'(8'h20 + k), 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(1, 8'hAB, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'h40 + k), 0, 0, 1);
    cyc(1, 8'h4F, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 8'(8'h60 + k), 0, 0, 1);
    cyc(1, 8'h6F, 1, 1, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h77, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 8'(8'h80 + k), 0, 0, 1);
    cyc(1, 8'h8F, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h99, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 600; k++) begin
      cyc(1'($urandom_range(0, 99) < 60),
          8'($urandom),
          1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 3),
          1'($urandom_range(0, 99) >= 1));
    end
    cyc(0, 8'h00, 1, 0, 1);
    for (int k = 0; k < 8; k++) cyc(0, 8'h00, 1, 0, 1);
    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
